// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write bus of the loader
interface imem_loader_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              im_write_enable;
  logic [ADDR_W-1:0] im_write_address;
  logic [31:0]       im_write_data;

  // Byte source and memory observer side.
  modport master (
    output in_valid, in_byte,
    input  in_ready, im_write_enable, im_write_address, im_write_data
  );

  // Loader side: consumes bytes, drives memory writes.
  modport slave (
    input  in_valid, in_byte,
    output in_ready, im_write_enable, im_write_address, im_write_data
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a length-prefixed big-endian program into imem, then releases the cpu
module imem_loader #(
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = 1024,
  parameter int RESET_HOLD = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_address,
  imem_loader_if.slave      bus,
  output logic              cpu_reset_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // A RESET_HOLD of 0 is treated as a single hold cycle.
  localparam int HOLD_LAST = (RESET_HOLD > 1) ? RESET_HOLD - 1 : 0;
  localparam int HOLD_W    = (HOLD_LAST > 0) ? $clog2(HOLD_LAST + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    RELEASE,
    DONE,
    ERR
  } state_t;

  state_t            state;
  state_t            next_state;

  logic [1:0]        byte_cnt;
  logic [23:0]       word;        // first three bytes of the word being assembled
  logic [31:0]       word_count;  // N from the header
  logic [31:0]       index;       // words written so far
  logic [ADDR_W-1:0] base_reg;
  logic [HOLD_W-1:0] hold_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  logic              in_ready_w;
  logic              we_w;
  logic              accept;
  logic              last_byte;
  logic              start_load;
  logic [31:0]       assembled;

  assign accept     = bus.in_valid && (state == HDR || state == DATA);
  assign last_byte  = accept && (byte_cnt == 2'd3);
  assign assembled  = {word, bus.in_byte};
  assign start_load = start && !busy;

  assign bus.in_ready         = in_ready_w;
  assign bus.im_write_enable  = we_w;
  assign bus.im_write_address = wr_addr;
  assign bus.im_write_data    = wr_data;

  // State register; reset returns to IDLE without waiting for a clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    next_state  = state;
    in_ready_w  = 1'b0;
    we_w        = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    cpu_reset_n = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = HDR;
      end
      HDR: begin
        in_ready_w = 1'b1;
        busy       = 1'b1;
        if (last_byte) begin
          if (assembled == 32'd0)              next_state = RELEASE;
          else if (assembled > 32'(DEPTH))     next_state = ERR;
          else                                 next_state = DATA;
        end
      end
      DATA: begin
        in_ready_w = 1'b1;
        busy       = 1'b1;
        if (last_byte) next_state = WRITE;
      end
      WRITE: begin
        we_w = 1'b1;
        busy = 1'b1;
        if (index + 32'd1 == word_count) next_state = RELEASE;
        else                             next_state = DATA;
      end
      RELEASE: begin
        busy = 1'b1;
        if (hold_cnt == HOLD_W'(HOLD_LAST)) next_state = DONE;
      end
      DONE: begin
        done = 1'b1;
        // A restart pulls the cpu back into reset in the same cycle.
        cpu_reset_n = !start;
        if (start) next_state = HDR;
      end
      ERR: begin
        error = 1'b1;
        if (start) next_state = HDR;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: word assembly, header capture, write pointer and release hold counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_cnt   <= 2'd0;
      word       <= 24'd0;
      word_count <= 32'd0;
      index      <= 32'd0;
      base_reg   <= '0;
      hold_cnt   <= '0;
      wr_addr    <= '0;
      wr_data    <= 32'd0;
    end else begin
      if (start_load) begin
        base_reg <= base_address;
        index    <= 32'd0;
        byte_cnt <= 2'd0;
      end
      if (accept) begin
        word     <= assembled[23:0];
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (state == HDR && last_byte) begin
        word_count <= assembled;
      end
      // Address and data are registered here so they hold after the strobe drops.
      if (state == DATA && last_byte) begin
        wr_addr <= base_reg + ADDR_W'(index);
        wr_data <= assembled;
      end
      if (state == WRITE) begin
        index <= index + 32'd1;
      end
      if (state == RELEASE) hold_cnt <= hold_cnt + 1'b1;
      else                  hold_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_address;
  logic        cpu_reset_n;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader_if #(.ADDR_W(32)) bus ();

  imem_loader #(
    .ADDR_W(32),
    .DEPTH(1024),
    .RESET_HOLD(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .base_address(base_address),
    .bus(bus),
    .cpu_reset_n(cpu_reset_n),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          acc_q[$];

  // Record every memory write with the cycle it occurred in.
  always @(negedge clock) begin
    if (bus.im_write_enable) begin
      wr_addr_q.push_back(bus.im_write_address);
      wr_data_q.push_back(bus.im_write_data);
      wr_cyc_q.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    acc_q.delete();
  endtask

  // All stimulus tasks start and end one time unit after a rising edge.
  task automatic do_start(input logic [31:0] base);
    start        = 1'b1;
    base_address = base;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    bus.in_valid = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        acc = cyc;
        got = 1'b1;
      end
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;
    if (!got) check("byte_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd, input int long_gap, output int acc);
    logic [31:0] sh;
    int          gap;
    sh = w;
    for (int k = 0; k < 4; k++) begin
      gap = rnd ? int'($urandom_range(0, 2)) : 0;
      if (k == 2) gap += long_gap;
      send_byte(sh[31:24], gap, acc);
      sh = sh << 8;
    end
  endtask

  task automatic wait_end(output int c);
    c = -1;
    for (int t = 0; t < 200 && c < 0; t++) begin
      @(negedge clock);
      if (done || error) c = cyc;
    end
    if (c < 0) check("done_or_error_timeout", 64'd0, 64'd1);
  endtask

  task automatic to_edge();
    @(posedge clock); #1;
  endtask

  int acc;
  int end_cyc;

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    base_address = 32'd0;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'd0;
    #1;
    check("rst_cpu_reset_n", cpu_reset_n, 0);
    check("rst_we",          bus.im_write_enable, 0);
    check("rst_in_ready",    bus.in_ready, 0);
    check("rst_busy_done_err", {busy, done, error}, 3'b000);
    repeat (2) to_edge();
    reset = 1'b0;
    to_edge();

    // Two-word program at 0x10.
    clear_logs();
    do_start(32'h10);
    check("start_busy", busy, 1);
    send_word(32'h0000_0002, 1'b0, 0, acc);
    send_word(32'h2001_0005, 1'b0, 0, acc); acc_q.push_back(acc);
    send_word(32'h8C22_0000, 1'b0, 0, acc); acc_q.push_back(acc);
    wait_end(end_cyc);
    check("p1_nwrites", wr_addr_q.size(), 2);
    if (wr_addr_q.size() == 2) begin
      check("p1_addr0", wr_addr_q[0], 32'h10);
      check("p1_data0", wr_data_q[0], 32'h2001_0005);
      check("p1_addr1", wr_addr_q[1], 32'h11);
      check("p1_data1", wr_data_q[1], 32'h8C22_0000);
      for (int i = 0; i < 2; i++) check("p1_latency", wr_cyc_q[i], acc_q[i] + 1);
      check("p1_release_hold", end_cyc, wr_cyc_q[1] + 1 + 4);
    end
    check("p1_done", {done, cpu_reset_n, busy, error}, 4'b1100);
    check("p1_hold_addr", {bus.im_write_enable, bus.im_write_address}, {1'b0, 32'h11});
    check("p1_hold_data", bus.im_write_data, 32'h8C22_0000);
    to_edge();

    // Restart from DONE, empty program.
    start        = 1'b1;
    base_address = 32'h20;
    @(negedge clock);
    check("restart_rstn_drop", {cpu_reset_n, done}, 2'b01);
    to_edge();
    start = 1'b0;
    check("restart_done_clear", {done, busy}, 2'b01);
    clear_logs();
    send_word(32'h0000_0000, 1'b0, 0, acc);
    wait_end(end_cyc);
    check("n0_nwrites", wr_addr_q.size(), 0);
    check("n0_release_hold", end_cyc, acc + 1 + 4);
    check("n0_done", {done, cpu_reset_n}, 2'b11);
    to_edge();

    // Oversized header.
    clear_logs();
    do_start(32'h0);
    send_word(32'h0000_0401, 1'b0, 0, acc);
    wait_end(end_cyc);
    check("err_cycle", end_cyc, acc + 1);
    check("err_outputs", {error, cpu_reset_n, bus.in_ready, done, busy}, 5'b10000);
    check("err_nwrites", wr_addr_q.size(), 0);
    to_edge();
    do_start(32'h200);
    check("err_restart", {busy, error, bus.in_ready}, 3'b101);

    // Random valid gaps with a 20-cycle stall between bytes 2 and 3.
    send_word(32'h0000_0002, 1'b1, 0, acc);
    send_word(32'h1234_5678, 1'b1, 20, acc); acc_q.push_back(acc);
    send_word(32'hCAFE_F00D, 1'b1, 20, acc); acc_q.push_back(acc);
    wait_end(end_cyc);
    check("gap_nwrites", wr_addr_q.size(), 2);
    if (wr_addr_q.size() == 2) begin
      check("gap_addr0", wr_addr_q[0], 32'h200);
      check("gap_data0", wr_data_q[0], 32'h1234_5678);
      check("gap_addr1", wr_addr_q[1], 32'h201);
      check("gap_data1", wr_data_q[1], 32'hCAFE_F00D);
      for (int i = 0; i < 2; i++) check("gap_latency", wr_cyc_q[i], acc_q[i] + 1);
    end
    to_edge();

    // Reset in the middle of the second word of a three-word load.
    clear_logs();
    do_start(32'h300);
    send_word(32'h0000_0003, 1'b0, 0, acc);
    send_word(32'hAABB_CCDD, 1'b0, 0, acc);
    send_byte(8'h11, 0, acc);
    send_byte(8'h22, 0, acc);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_rstn_we_rdy", {cpu_reset_n, bus.im_write_enable, bus.in_ready}, 3'b000);
    check("async_rst_flags", {busy, done, error}, 3'b000);
    check("async_rst_addr", bus.im_write_address, 32'h0);
    check("async_rst_data", bus.im_write_data, 32'h0);
    repeat (2) to_edge();
    reset = 1'b0;
    repeat (3) to_edge();
    check("abort_nwrites", wr_addr_q.size(), 1);
    if (wr_data_q.size() >= 1) check("abort_data0", wr_data_q[0], 32'hAABB_CCDD);

    clear_logs();
    do_start(32'h40);
    send_word(32'h0000_0003, 1'b0, 0, acc);
    send_word(32'h0000_0001, 1'b0, 0, acc);
    send_word(32'hFFFF_FFFE, 1'b0, 0, acc);
    send_word(32'h0102_0304, 1'b0, 0, acc);
    wait_end(end_cyc);
    check("reload_nwrites", wr_addr_q.size(), 3);
    if (wr_addr_q.size() == 3) begin
      check("reload_w0", {wr_addr_q[0], wr_data_q[0]}, {32'h40, 32'h0000_0001});
      check("reload_w1", {wr_addr_q[1], wr_data_q[1]}, {32'h41, 32'hFFFF_FFFE});
      check("reload_w2", {wr_addr_q[2], wr_data_q[2]}, {32'h42, 32'h0102_0304});
    end
    to_edge();

    // Address wraps past the top of the address space.
    clear_logs();
    do_start(32'hFFFF_FFFF);
    send_word(32'h0000_0002, 1'b0, 0, acc);
    send_word(32'hDEAD_BEEF, 1'b0, 0, acc);
    send_word(32'h0BAD_F00D, 1'b0, 0, acc);
    wait_end(end_cyc);
    check("wrap_nwrites", wr_addr_q.size(), 2);
    if (wr_addr_q.size() == 2) begin
      check("wrap_w0", {wr_addr_q[0], wr_data_q[0]}, {32'hFFFF_FFFF, 32'hDEAD_BEEF});
      check("wrap_w1", {wr_addr_q[1], wr_data_q[1]}, {32'h0000_0000, 32'h0BAD_F00D});
    end
    check("wrap_done", {done, cpu_reset_n}, 2'b11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
